// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one handshaked single-ported memory between the
// instruction-fetch port (I) and the data load/store port (D). One access is
// in flight at a time. Ties are resolved round-robin, responses are
// registered, and a watchdog aborts accesses that never see m_ack.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_valid,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_rd,
  input  logic                    d_wr,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH/8-1:0] d_mask,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_valid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    err,
  output logic                    m_req,
  output logic                    m_we,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH/8-1:0] m_mask,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  input  logic                    m_ack,
  input  logic [DATA_WIDTH-1:0]   m_rdata
);

  localparam int MASK_W = DATA_WIDTH / 8;
  // Counter only needs to reach TIMEOUT-1; keep at least one bit when disabled.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                  state_q,      state_d;
  logic                    last_grant_q, last_grant_d;
  logic [CW-1:0]           cnt_q,        cnt_d;
  logic                    m_req_q,      m_req_d;
  logic                    m_we_q,       m_we_d;
  logic [ADDR_WIDTH-1:0]   m_addr_q,     m_addr_d;
  logic [MASK_W-1:0]       m_mask_q,     m_mask_d;
  logic [DATA_WIDTH-1:0]   m_wdata_q,    m_wdata_d;
  logic                    i_valid_q,    i_valid_d;
  logic                    d_valid_q,    d_valid_d;
  logic                    err_q,        err_d;
  logic [DATA_WIDTH-1:0]   i_rdata_q,    i_rdata_d;
  logic [DATA_WIDTH-1:0]   d_rdata_q,    d_rdata_d;

  logic                    d_any;
  logic                    timeout_hit;
  logic                    grant_i;
  logic                    grant_d;
  logic [DATA_WIDTH-1:0]   resp_data;

  assign d_any       = d_rd | d_wr;
  // Fires in the last permitted wait cycle; an m_ack in that same cycle wins.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  // Next-state, grant, watchdog and response logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_mask_d     = m_mask_q;
    m_wdata_d    = m_wdata_q;
    i_valid_d    = 1'b0;
    d_valid_d    = 1'b0;
    err_d        = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    resp_data    = '0;

    case (state_q)
      IDLE: begin
        grant_i = i_req & (~d_any | (last_grant_q == GRANT_D));
        grant_d = d_any & ~grant_i;
        if (grant_i) begin
          state_d      = BUSY_I;
          last_grant_d = GRANT_I;
          cnt_d        = '0;
          m_req_d      = 1'b1;
          m_we_d       = 1'b0;
          m_addr_d     = i_addr;
          m_mask_d     = '1;
          m_wdata_d    = '0;
        end else if (grant_d) begin
          state_d      = BUSY_D;
          last_grant_d = GRANT_D;
          cnt_d        = '0;
          m_req_d      = 1'b1;
          m_we_d       = d_wr;
          m_addr_d     = d_addr;
          m_mask_d     = d_mask;
          m_wdata_d    = d_wdata;
        end else begin
          state_d = IDLE;
        end
      end

      BUSY_I, BUSY_D: begin
        // Stores and aborted accesses return zero data.
        if (m_ack && !m_we_q) begin
          resp_data = m_rdata;
        end else begin
          resp_data = '0;
        end
        if (m_ack || timeout_hit) begin
          state_d = RESP;
          m_req_d = 1'b0;
          err_d   = ~m_ack;
          if (state_q == BUSY_I) begin
            i_valid_d = 1'b1;
            i_rdata_d = resp_data;
          end else begin
            d_valid_d = 1'b1;
            d_rdata_d = resp_data;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      cnt_q        <= '0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_mask_q     <= '0;
      m_wdata_q    <= '0;
      i_valid_q    <= 1'b0;
      d_valid_q    <= 1'b0;
      err_q        <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_mask_q     <= m_mask_d;
      m_wdata_q    <= m_wdata_d;
      i_valid_q    <= i_valid_d;
      d_valid_q    <= d_valid_d;
      err_q        <= err_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign m_req   = m_req_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_mask  = m_mask_q;
  assign m_wdata = m_wdata_q;
  assign i_valid = i_valid_q;
  assign d_valid = d_valid_q;
  assign err     = err_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule
